vram_fetch_arbiter: RTL and testbench

- Schedules a single-port video memory shared by two requesters: display line prefetch and the CPU.
- Driven by the pixel-domain timing counters from the VGA sync generator.
- During horizontal blanking it fetches the next visible line into one bank of a double-buffered line buffer; the scanout logic reads the other bank.
- CPU accesses are interleaved under a fairness quota. A sticky underrun flag reports any line not fetched before its display start.

---
 rtl/vram_fetch_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_vram_fetch_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_fetch_arbiter.sv
// Video memory arbiter: prefetches the next visible line into a double-buffered line buffer during
// horizontal blanking and interleaves CPU accesses under a fairness quota. Define VRAM_UNDERRUN_CNT_EN to add underrun_cnt.
module vram_fetch_arbiter #(
  parameter int H_DISPLAY = 800,
  parameter int V_DISPLAY = 600,
  parameter int V_LAST    = 666,
  parameter int WORDS     = 200,
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 16,
  parameter int FAIR      = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [10:0]            counterX,
  input  logic [9:0]             counterY,
  input  logic [ADDR_W-1:0]      fb_base,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  output logic                   cpu_ack,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic                   mem_ack,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic                   lb_we,
  output logic [$clog2(WORDS):0] lb_addr,
  output logic [DATA_W-1:0]      lb_wdata,
  output logic                   lb_rd_bank,
  output logic                   underrun,
  input  logic                   underrun_clr
`ifdef VRAM_UNDERRUN_CNT_EN
  ,
  output logic [7:0]             underrun_cnt
`endif
);

  localparam int WI_W = $clog2(WORDS);
  localparam int FC_W = $clog2(FAIR + 1);

  typedef enum logic [1:0] {IDLE, FETCH, CPU} state_t;

  state_t            state;
  logic              fetch_pending;
  logic              fetch_done;
  logic              discard;
  logic [FC_W-1:0]   fair_cnt;
  logic [ADDR_W-1:0] line_addr;
  logic [WI_W-1:0]   word_idx;
  logic [9:0]        target_line;

  logic       trigger;
  logic [9:0] target;
  logic       target_vis;
  logic       disp_start;
  logic       late;
  logic       underrun_evt;
  logic       grant_fetch;
  logic       grant_cpu;

  assign trigger      = (counterX == 11'(H_DISPLAY));
  assign target       = (counterY == 10'(V_LAST)) ? 10'd0 : counterY + 10'd1;
  assign target_vis   = (target < 10'(V_DISPLAY));
  assign disp_start   = (counterX == 11'd0) && (counterY == target_line);
  assign late         = disp_start && fetch_pending;
  assign underrun_evt = late || (trigger && fetch_pending);
  assign grant_fetch  = fetch_pending && ((fair_cnt < FC_W'(FAIR)) || !cpu_req);
  // cpu_ack gating keeps a still-held request from being granted twice
  assign grant_cpu    = cpu_req && !cpu_ack && (!fetch_pending || (fair_cnt >= FC_W'(FAIR)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      fetch_pending <= 1'b0;
      fetch_done    <= 1'b0;
      discard       <= 1'b0;
      fair_cnt      <= '0;
      line_addr     <= '0;
      word_idx      <= '0;
      target_line   <= '0;
      cpu_ack       <= 1'b0;
      cpu_rdata     <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      lb_we         <= 1'b0;
      lb_addr       <= '0;
      lb_wdata      <= '0;
      lb_rd_bank    <= 1'b1;
      underrun      <= 1'b0;
    end else begin
      lb_we   <= 1'b0;
      cpu_ack <= 1'b0;
      case (state)
        IDLE: begin
          // Line pointers move on trigger/display-start cycles, so no fetch is launched then
          if (grant_fetch && !trigger && !late) begin
            state     <= FETCH;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= line_addr + ADDR_W'(word_idx);
            mem_wdata <= '0;
          end else if (grant_cpu) begin
            state     <= CPU;
            mem_req   <= 1'b1;
            mem_we    <= cpu_we;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            discard <= 1'b0;
            if (fair_cnt < FC_W'(FAIR)) fair_cnt <= fair_cnt + FC_W'(1);
            if (!discard) begin
              lb_we    <= !underrun_evt;
              lb_addr  <= {~lb_rd_bank, word_idx};
              lb_wdata <= mem_rdata;
              word_idx <= word_idx + WI_W'(1);
              if (word_idx == WI_W'(WORDS - 1)) begin
                fetch_pending <= 1'b0;
                fetch_done    <= 1'b1;
              end
            end
          end
        end
        CPU: begin
          if (mem_ack) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            cpu_ack   <= 1'b1;
            cpu_rdata <= mem_rdata;
            fair_cnt  <= '0;
          end
        end
        default: state <= IDLE;
      endcase

      if (disp_start && !fetch_pending && fetch_done) begin
        lb_rd_bank <= ~lb_rd_bank;
        fetch_done <= 1'b0;
      end

      // Abandoned line: an access still in flight completes but its data is thrown away
      if (underrun_evt) begin
        fetch_pending <= 1'b0;
        fetch_done    <= 1'b0;
        if (state == FETCH && !mem_ack) discard <= 1'b1;
      end

      if (trigger) begin
        line_addr <= (target == 10'd0) ? fb_base : line_addr + ADDR_W'(WORDS);
        if (target_vis) begin
          fetch_pending <= 1'b1;
          fetch_done    <= 1'b0;
          word_idx      <= '0;
          target_line   <= target;
        end
      end

      if (underrun_evt)      underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;
    end
  end

`ifdef VRAM_UNDERRUN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_cnt <= '0;
    end else if (underrun_evt) begin
      if (underrun_clr)                underrun_cnt <= 8'd1;
      else if (underrun_cnt != 8'hFF)  underrun_cnt <= underrun_cnt + 8'd1;
    end else if (underrun_clr) begin
      underrun_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_vram_fetch_arbiter.sv
// Scoreboard bench for vram_fetch_arbiter: directed line fetches, CPU contention, underrun and reset cases.
module tb_vram_fetch_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] counterX;
  logic [9:0]  counterY;
  logic [17:0] fb_base;
  logic        cpu_req, cpu_we;
  logic [17:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        mem_req, mem_we;
  logic [17:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0;
  logic        lb_we;
  logic [8:0]  lb_addr;
  logic [15:0] lb_wdata;
  logic        lb_rd_bank;
  logic        underrun;
  logic        underrun_clr;
`ifdef VRAM_UNDERRUN_CNT_EN
  logic [7:0]  underrun_cnt;
`endif

  vram_fetch_arbiter dut (
    .clk(clk), .rst_n(rst_n), .counterX(counterX), .counterY(counterY), .fb_base(fb_base),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .lb_we(lb_we), .lb_addr(lb_addr), .lb_wdata(lb_wdata), .lb_rd_bank(lb_rd_bank),
    .underrun(underrun), .underrun_clr(underrun_clr)
`ifdef VRAM_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [8:0] addr; logic [15:0] data; } lb_t;

  lb_t         exp_lb[$];
  logic [16:0] exp_cpu[$];
  lb_t         lb_e;
  logic [16:0] cpu_e;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mem_lat = 1;
  int lat_cnt = 0;
  bit lat_en = 0;
  bit gap_en = 0;
  bit gap_en_q = 0;
  int lb_since = 0;
  int gap_idx = 0;
  logic        prev_req = 1'b0, prev_ack = 1'b0;
  logic [17:0] prev_addr = '0;
  logic [17:0] wr_addr = '0;
  logic [15:0] wr_data = '0;

  function automatic logic [15:0] mem_f(input logic [17:0] a);
    return a[15:0] ^ 16'hC3A5 ^ {14'd0, a[17:16]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_line(input logic [17:0] base, input logic bank);
    for (int i = 0; i < 200; i++) begin
      lb_e.addr = {bank, 8'(i)};
      lb_e.data = mem_f(base + 18'(i));
      exp_lb.push_back(lb_e);
    end
  endtask

  task automatic wait_lb(input int budget);
    int n;
    n = 0;
    while (exp_lb.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    check("line_fetch_done", 64'(exp_lb.size()), 64'd0);
    exp_lb.delete();
  endtask

  task automatic cpu_access(input logic we, input logic [17:0] addr, input logic [15:0] wdata);
    int n;
    int t_req;
    bit seen;
    n = 0;
    t_req = 0;
    seen = 0;
    exp_cpu.push_back({~we, we ? 16'h0 : mem_f(addr)});
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = addr;
    cpu_wdata = wdata;
    do begin
      step(1);
      n++;
      if (!seen && mem_req) begin
        seen = 1;
        t_req = cyc;
      end
    end while (!cpu_ack && n < 300);
    if (!cpu_ack) begin
      checks++;
      errors++;
      $display("FAIL cpu_timeout: got no cpu_ack after %0d cycles, required an ack", n);
    end else begin
      if (lat_en) check("cpu_latency", 64'(cyc - t_req), 64'd2);
      if (we) check("cpu_write", {wr_addr, wr_data}, {addr, wdata});
    end
    cpu_req = 1'b0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: acks mem_lat cycles after a request is first seen, data derived from address
  always @(posedge clk) begin
    if (mem_req && !mem_ack) begin
      if (lat_cnt + 1 >= mem_lat) begin
        mem_ack   <= 1'b1;
        mem_rdata <= mem_f(mem_addr);
        lat_cnt   <= 0;
        if (mem_we) begin
          wr_addr <= mem_addr;
          wr_data <= mem_wdata;
        end
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end else begin
      mem_ack <= 1'b0;
      lat_cnt <= 0;
    end
  end

  // Monitor: pops the scoreboard on every line-buffer write and CPU completion
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
      prev_ack = 1'b0;
    end else begin
      if (gap_en && !gap_en_q) begin
        lb_since = 0;
        gap_idx = 0;
      end
      gap_en_q = gap_en;
      if (lb_we) begin
        if (exp_lb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL lb_unexpected: got write addr=%0h data=%0h, required no write", lb_addr, lb_wdata);
        end else begin
          lb_e = exp_lb.pop_front();
          check("lb_write", {lb_addr, lb_wdata}, {lb_e.addr, lb_e.data});
        end
        lb_since++;
      end
      if (cpu_ack) begin
        if (exp_cpu.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cpu_unexpected: got cpu_ack, required none");
        end else begin
          cpu_e = exp_cpu.pop_front();
          if (cpu_e[16]) check("cpu_rdata", cpu_rdata, cpu_e[15:0]);
        end
        if (gap_en) begin
          check("fair_gap", 64'(lb_since), (gap_idx == 0) ? 64'd0 : 64'd8);
          gap_idx++;
          lb_since = 0;
        end
      end
      if (prev_req && !prev_ack) check("mem_hold", {mem_req, mem_addr}, {1'b1, prev_addr});
      prev_req = mem_req;
      prev_ack = mem_ack;
      prev_addr = mem_addr;
    end
  end

  initial begin
    bit any_req;
    rst_n = 1'b0;
    counterX = 11'd100;
    counterY = 10'd9;
    fb_base = '0;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    underrun_clr = 1'b0;
    step(3);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_lb_we", lb_we, 0);
    check("rst_lb_addr", lb_addr, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_underrun", underrun, 0);
    check("rst_rd_bank", lb_rd_bank, 1);
    rst_n = 1'b1;
    step(2);

    // Line 10 from reset line_addr 0 + 200, written to bank 0
    push_line(18'd200, 1'b0);
    counterX = 11'd800;
    step(1);
    counterX = 11'd801;
    wait_lb(2000);
    step(5);
    check("t1_underrun", underrun, 0);
    check("t1_no_early_swap", lb_rd_bank, 1);
    check("t1_idle", mem_req, 0);
    counterY = 10'd10;
    counterX = 11'd0;
    step(1);
    check("t1_swap", lb_rd_bank, 0);
    counterX = 11'd1;

    // Wrap to line 0 at fb_base, bank 1
    fb_base = 18'h1000;
    push_line(18'h1000, 1'b1);
    counterY = 10'd666;
    counterX = 11'd800;
    step(1);
    counterX = 11'd801;
    wait_lb(2000);
    counterY = 10'd0;
    counterX = 11'd0;
    step(1);
    check("t2_swap", lb_rd_bank, 1);
    counterX = 11'd1;

    // Line 1 at 0x10C8 with a CPU request held throughout; quota starts saturated
    push_line(18'h10C8, 1'b0);
    counterX = 11'd800;
    step(1);
    counterX = 11'd801;
    gap_en = 1;
    for (int k = 0; k < 26; k++) cpu_access(1'b0, 18'h3F000 + 18'(k), 16'h0);
    wait_lb(500);
    step(1);
    gap_en = 0;
    check("t3_cpu_count", 64'(gap_idx), 64'd26);
    counterY = 10'd1;
    counterX = 11'd0;
    step(1);
    check("t3_swap", lb_rd_bank, 0);
    counterX = 11'd1;

    // Target 600 is invisible: no fetch, CPU serviced back-to-back
    counterY = 10'd599;
    counterX = 11'd800;
    step(1);
    counterX = 11'd801;
    any_req = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (mem_req) any_req = 1;
    end
    check("t5_no_fetch", any_req, 0);
    lat_en = 1;
    cpu_access(1'b0, 18'h00123, 16'h0);
    cpu_access(1'b1, 18'h00456, 16'hBEEF);
    cpu_access(1'b0, 18'h00789, 16'h0);
    lat_en = 0;

    // Slow memory: line 0 cannot finish before display start
    mem_lat = 10;
    fb_base = 18'h2000;
    push_line(18'h2000, 1'b1);
    counterY = 10'd666;
    counterX = 11'd800;
    step(1);
    counterX = 11'd801;
    step(100);
    counterY = 10'd0;
    counterX = 11'd0;
    step(1);
    counterX = 11'd1;
    check("t4_fetch_incomplete", exp_lb.size() > 0, 1);
    exp_lb.delete();
    check("t4_underrun", underrun, 1);
    check("t4_no_swap", lb_rd_bank, 0);
    step(30);
    check("t4_sticky", underrun, 1);
    check("t4_fetch_dropped", mem_req, 0);
    underrun_clr = 1'b1;
    step(1);
    underrun_clr = 1'b0;
    check("t4_clear", underrun, 0);

    // Back-to-back triggers: restart underrun, refetch from 0x2000 + 2*200
    mem_lat = 1;
    push_line(18'h2190, 1'b1);
    counterY = 10'd9;
    counterX = 11'd800;
    step(2);
    counterX = 11'd801;
    check("t6_restart_underrun", underrun, 1);
`ifdef VRAM_UNDERRUN_CNT_EN
    check("t6_cnt", underrun_cnt, 1);
`endif
    wait_lb(2000);
    underrun_clr = 1'b1;
    step(1);
    underrun_clr = 1'b0;
    check("t6_clear", underrun, 0);

`ifdef VRAM_UNDERRUN_CNT_EN
    check("cnt_cleared", underrun_cnt, 0);
    counterX = 11'd800;
    step(310);
    check("cnt_saturate", underrun_cnt, 8'd255);
`endif

    // Reset in the middle of a fetch access
    counterY = 10'd9;
    counterX = 11'd800;
    step(1);
    counterX = 11'd801;
    step(1);
    check("inflight_req", mem_req, 1);
    rst_n = 1'b0;
    #1;
    check("reset_abort_req", mem_req, 0);
    check("reset_rd_bank", lb_rd_bank, 1);
    check("reset_underrun", underrun, 0);
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
